// File: rtl/control_sequencer.sv
// Microcoded control unit: instruction register, microstep counter and halt latch,
// producing the per-step control word from opcode, step and ALU flags.
module control_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3,
  parameter int EARLY_END    = 1
) (
  input  logic                    i_CLOCK,
  input  logic                    i_CLEAR,
  input  logic [DATA_WIDTH-1:0]   i_BUS,
  input  logic                    i_FLAG_CARRY,
  input  logic                    i_FLAG_ZERO,
  output logic [15:0]             o_CONTROL,
  output logic [DATA_WIDTH-1:0]   o_OPERAND,
  output logic [OPCODE_WIDTH-1:0] o_OPCODE,
  output logic [STEP_WIDTH-1:0]   o_STEP,
  output logic                    o_HALTED
);

  localparam int OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;
  localparam logic [STEP_WIDTH-1:0] LAST_STEP = '1;

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  typedef enum logic {RUN, HALT} state_t;

  state_t                  state_reg, state_next;
  logic [STEP_WIDTH-1:0]   step_reg, step_next;
  logic [DATA_WIDTH-1:0]   ir_reg, ir_next;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [15:0]             cur_word, look_word;

  // Microcode ROM as a pure function so the early-end lookahead can reuse it.
  function automatic logic [15:0] micro_word(
    input logic [OPCODE_WIDTH-1:0] opc,
    input logic [STEP_WIDTH-1:0]   step,
    input logic                    carry,
    input logic                    zero
  );
    logic [15:0] w;
    logic        t2, t3, t4;
    w  = '0;
    t2 = (step == STEP_WIDTH'(2));
    t3 = (step == STEP_WIDTH'(3));
    t4 = (step == STEP_WIDTH'(4));
    if (step == STEP_WIDTH'(0)) begin
      w = C_CO | C_MI;
    end else if (step == STEP_WIDTH'(1)) begin
      w = C_RO | C_II | C_CE;
    end else if ((opc >> 4) == '0) begin
      case (opc[3:0])
        4'h1: w = t2 ? (C_IO | C_MI) : t3 ? (C_RO | C_AI) : '0;
        4'h2: w = t2 ? (C_IO | C_MI) : t3 ? (C_RO | C_BI) : t4 ? (C_EO | C_AI | C_FI) : '0;
        4'h3: w = t2 ? (C_IO | C_MI) : t3 ? (C_RO | C_BI) : t4 ? (C_EO | C_AI | C_SU | C_FI) : '0;
        4'h4: w = t2 ? (C_IO | C_MI) : t3 ? (C_AO | C_RI) : '0;
        4'h5: w = t2 ? (C_IO | C_AI) : '0;
        4'h6: w = t2 ? (C_IO | C_J) : '0;
        4'h7: w = (t2 && carry) ? (C_IO | C_J) : '0;
        4'h8: w = (t2 && zero) ? (C_IO | C_J) : '0;
        4'hE: w = t2 ? (C_AO | C_OI) : '0;
        4'hF: w = t2 ? C_HLT : '0;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  assign opcode    = ir_reg[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign cur_word  = micro_word(opcode, step_reg, i_FLAG_CARRY, i_FLAG_ZERO);
  assign look_word = micro_word(opcode, step_reg + STEP_WIDTH'(1), i_FLAG_CARRY, i_FLAG_ZERO);

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    ir_next    = ir_reg;
    o_CONTROL  = cur_word;
    if (state_reg == HALT) begin
      o_CONTROL = C_HLT;
    end else if (cur_word[15]) begin
      // HLT freezes step and IR where they are.
      state_next = HALT;
    end else begin
      if (cur_word[10])
        ir_next = i_BUS;
      if (step_reg == LAST_STEP)
        step_next = '0;
      else if ((EARLY_END != 0) && (step_reg >= STEP_WIDTH'(2)) && (look_word == '0))
        step_next = '0;
      else
        step_next = step_reg + STEP_WIDTH'(1);
    end
  end

  always_ff @(posedge i_CLOCK) begin
    if (i_CLEAR) begin
      state_reg <= RUN;
      step_reg  <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      ir_reg    <= ir_next;
    end
  end

  assign o_OPCODE  = opcode;
  assign o_OPERAND = {{OPCODE_WIDTH{1'b0}}, ir_reg[OPERAND_WIDTH-1:0]};
  assign o_STEP    = step_reg;
  assign o_HALTED  = (state_reg == HALT);

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised microcoded control unit for the bus-based CPU.
- Replaces the hand-driven control lines at the top level: it holds the instruction register, steps a microstep counter, and produces the full per-step control word from opcode, step and ALU flags.
- Adds halt latching, flag-conditional jumps, and an optional early end of instruction.
- Clocked by the CPU clock from the clock module; the top level inverts control bits where downstream inputs are active-low.

Parameters:
DATA_WIDTH, 8, bus width; instruction = opcode in the upper OPCODE_WIDTH bits, operand in the remaining low bits.
OPCODE_WIDTH, 4, opcode field width; must be >= 4.
STEP_WIDTH, 3, microstep counter width, giving 2^STEP_WIDTH steps; must be >= 3.
EARLY_END, 1, 1 = terminate an instruction after its last non-zero step; 0 = always run all 2^STEP_WIDTH steps.

Ports:
i_CLOCK  input  1  CPU clock; all state updates on the rising edge.
i_CLEAR  input  1  synchronous active-high reset.
i_BUS  input  DATA_WIDTH  shared bus; sampled into the IR when II=1.
i_FLAG_CARRY  input  1  latched carry flag from the ALU flags register.
i_FLAG_ZERO  input  1  latched zero flag from the ALU flags register.
o_CONTROL  output  16  control word, active-high: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
o_OPERAND  output  DATA_WIDTH  IR operand field, zero-extended; the bus driver enables it when IO=1.
o_OPCODE  output  OPCODE_WIDTH  IR opcode field.
o_STEP  output  STEP_WIDTH  current microstep.
o_HALTED  output  1  halt latched.

Behaviour:
- Reset (i_CLEAR=1 at an edge): IR=0, step=0, halted=0.
  - After reset: o_CONTROL=0x4004, o_OPCODE=0, o_OPERAND=0, o_STEP=0, o_HALTED=0.
  - i_CLEAR has priority over everything, including mid-instruction and while halted.
- o_CONTROL is combinational from the registered IR, step and halted state plus the flag inputs. There is no extra latency.
  - While halted, o_CONTROL is forced to 0x8000.
- Fetch steps (all opcodes):
  - T0: CO|MI.
  - T1: RO|II|CE. The IR loads i_BUS at the end of T1.
- Execute steps (T2 onward). All steps not listed are 0.
  - 0000 NOP: none.
  - 0001 LDA: T2 IO|MI; T3 RO|AI.
  - 0010 ADD: T2 IO|MI; T3 RO|BI; T4 EO|AI|FI.
  - 0011 SUB: as ADD, with T4 = EO|AI|SU|FI.
  - 0100 STA: T2 IO|MI; T3 AO|RI.
  - 0101 LDI: T2 IO|AI.
  - 0110 JMP: T2 IO|J.
  - 0111 JC: T2 IO|J if i_FLAG_CARRY=1, else 0.
  - 1000 JZ: T2 IO|J if i_FLAG_ZERO=1, else 0.
  - 1110 OUT: T2 AO|OI.
  - 1111 HLT: T2 HLT.
  - All other opcodes: NOP. Opcode bits above bit 3 must be 0 to decode.
- Step advance (when not halted and not clearing):
  - Next step = 0 if step = 2^STEP_WIDTH-1.
  - Otherwise, with EARLY_END=1: if step >= 2 and the control word for step+1 (same opcode, current flags) is 0, next step = 0.
  - Otherwise, step+1.
  - Step 2 always executes, even when its word is 0.
  - Resulting lengths with EARLY_END=1: NOP, JC-not-taken and JZ-not-taken take 3 cycles; LDA and STA take 4; ADD and SUB take 5.
- Halt:
  - On an edge where HLT=1 and not clearing: halted is set, and step and IR freeze.
  - Halted holds until i_CLEAR.
- The IR loads only when II=1. It is never written outside T1.
- Flags are evaluated in the cycle of use. A flag change within T2 changes o_CONTROL in the same cycle.

Test Plan:
- Reset: i_CLEAR=1 for one edge -> o_STEP=0, o_CONTROL=0x4004, o_HALTED=0, o_OPCODE=0.
- LDA, EARLY_END=1: i_BUS=0x1A at T1 ->
  - T1 o_CONTROL=0x1408;
  - T2 0x4800 with o_OPERAND=0x0A;
  - T3 0x1200;
  - next edge o_STEP=0.
- ADD/SUB, EARLY_END=0: i_BUS=0x2C ->
  - T4=0x0281;
  - steps 5-7 = 0x0000;
  - o_STEP wraps 7->0.
  - Repeat with 0x3C -> T4=0x02C1.
- JC: i_BUS=0x75, carry=0 -> T2=0x0000, then step 0 (3 cycles). Carry=1 -> T2=0x0802. Repeat with JZ 0x85 using the zero flag.
- HLT: i_BUS=0xF0 ->
  - T2=0x8000;
  - next edge o_HALTED=1, with o_STEP=2 and o_CONTROL=0x8000 held for 10 cycles;
  - i_CLEAR -> o_STEP=0, o_CONTROL=0x4004, o_HALTED=0.
- Clear mid-instruction: assert i_CLEAR at ADD T3 -> next cycle o_STEP=0, o_OPCODE=0, o_CONTROL=0x4004; the following fetch runs normally.
